reg_scoreboard: RTL and testbench
=================================

Name: reg_scoreboard

Overview:
- Issue-stage scoreboard that sequences access to the 32x32 register file (two read ports, one write port, r0 hardwired to zero).
- Tracks in-flight writes per architectural register.
- Stalls issue on RAW hazards until each source is forwardable, and on WAW ordering hazards.
- Retires entries on writeback. Sits between decode and execute; `stall` feeds the IF/ID hold logic.

Parameters:
- NREG, 32, number of architectural registers (index 0 is never tracked)
- AW, 5, register address width
- LW, 3, width of latency countdown per register
- OW, 2, width of outstanding-write counter per register (max 2^OW-1 in flight per register)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- issue_valid  in  1  decode presents an instruction
- issue_rs1  in  AW  source 1 address
- issue_rs2  in  AW  source 2 address
- issue_use_rs1  in  1  instruction reads rs1
- issue_use_rs2  in  1  instruction reads rs2
- issue_wen  in  1  instruction writes rd
- issue_rd  in  AW  destination address
- issue_lat  in  LW  cycles after issue until result is forwardable (0 = next cycle)
- wb_valid  in  1  writeback completing this cycle
- wb_addr  in  AW  writeback destination
- flush  in  1  pipeline flush; discard all in-flight tracking
- stall  out  1  hold issue this cycle (combinational)
- issue_fire  out  1  issue_valid & !stall
- busy_mask  out  NREG  bit i = register i has outstanding writes (registered)
- inflight  out  6  total outstanding writes across all registers (registered)

Behaviour:
- State per register i (1..NREG-1): `oc[i]` (OW bits, outstanding writes) and `cnt[i]` (LW bits, cycles until newest write forwardable). Register 0 has no state; `busy_mask[0]` is always 0.
- Reset (`rst`=1 at posedge): all `oc`, `cnt` = 0; `busy_mask` = 0; `inflight` = 0. `stall` = 0 while `issue_valid` = 0.
- RAW hazard: `use_rsX` & `rsX`!=0 & `oc[rsX]`!=0 & `cnt[rsX]`!=0, for either source.
- WAW hazard: `issue_wen` & `rd`!=0 & `oc[rd]`!=0 & `cnt[rd]` > `issue_lat`.
- Capacity hazard: `issue_wen` & `rd`!=0 & `oc[rd]` == 2^OW-1.
- `stall` = `issue_valid` & (RAW | WAW | capacity). It is purely combinational from current state and issue inputs. `wb` in the same cycle does not unstall that cycle.
- On `issue_fire` & `issue_wen` & `rd`!=0: `oc[rd]` += 1; `cnt[rd]` <= `issue_lat`.
- On `wb_valid` & `wb_addr`!=0 & `oc[wb_addr]`!=0: `oc[wb_addr]` -= 1. A writeback to an untracked register or to r0 is ignored (no underflow).
- Same register issued and written back in one cycle: net `oc` unchanged; `cnt` loaded with `issue_lat`.
- Every other register with `cnt`!=0 decrements by 1 per cycle, saturating at 0. A freshly loaded `cnt` is not decremented that cycle.
- When `oc[i]` returns to 0, `cnt[i]` is forced to 0.
- `flush` (registered effect): all `oc`/`cnt` cleared next cycle, same as reset. Issue/wb in the flush cycle are dropped. `stall` is still computed from pre-flush state in the flush cycle.
- `rst` has priority over `flush`, `flush` over issue/wb.
- `busy_mask[i]` = (`oc[i]`!=0); `inflight` = sum of `oc`. Both are updated at the same edge as the state.

Test Plan:
- Reset, then issue rd=5, lat=2 → cycle+1: `busy_mask`=0x20, `inflight`=1. Issue use rs1=5 at cycle+1 stalls; cycle+2 stalls; cycle+3 fires.
- Issue rd=0, lat=3, then an instruction reading r0 → never stalls; `busy_mask` stays 0.
- Issue rd=7 lat=4; next cycle issue rd=7 lat=1 → stall (WAW) until `cnt[7]`≤1, then fires; `oc[7]`=2. Two wb to 7 → `busy_mask[7]` clears after the second.
- Three writes to rd=9 outstanding (OW=2), fourth issue to rd=9 → stall until a wb to 9 occurs.
- Issue rd=3 and wb_addr=3 in the same cycle with `oc[3]`=1 → `oc[3]` stays 1, `cnt[3]`=`issue_lat`; wb to register 12 with `oc`=0 → no change.
- With `inflight`=4 and pending stall, assert `flush` → next cycle `busy_mask`=0, `inflight`=0, stall=0. Repeat with `rst` mid-sequence → same result.

Source files
------------

// File: rtl/reg_scoreboard.sv
// reg_scoreboard
//   Issue-stage scoreboard for a 32x32 register file with r0 hardwired to zero.
//   Each architectural register (except r0) carries an outstanding-write count
//   and a countdown until its newest write becomes forwardable. Issue is held
//   on RAW, WAW-ordering and per-register capacity hazards.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   issue_*              instruction presented by decode
//   wb_valid, wb_addr    writeback retiring one outstanding write
//   flush                discard all in-flight tracking (takes effect next cycle)
//   stall                combinational issue hold
//   issue_fire           issue_valid & !stall
//   busy_mask            registered: bit i set while register i has writes in flight
//   inflight             registered: total outstanding writes
module reg_scoreboard #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int LW   = 3,
  parameter int OW   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rs1,
  input  logic [AW-1:0]   issue_rs2,
  input  logic            issue_use_rs1,
  input  logic            issue_use_rs2,
  input  logic            issue_wen,
  input  logic [AW-1:0]   issue_rd,
  input  logic [LW-1:0]   issue_lat,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_addr,
  input  logic            flush,
  output logic            stall,
  output logic            issue_fire,
  output logic [NREG-1:0] busy_mask,
  output logic [5:0]      inflight
);

  // Entry 0 exists only so source/destination addresses can index directly;
  // it is never written and stays zero.
  logic [OW-1:0] oc_q  [NREG];
  logic [OW-1:0] oc_d  [NREG];
  logic [LW-1:0] cnt_q [NREG];
  logic [LW-1:0] cnt_d [NREG];

  logic [NREG-1:0] busy_d;
  logic [5:0]      inflight_d;

  logic raw1, raw2, waw, cap;
  logic iss_hit, wb_hit;

  always_comb begin
    raw1 = issue_use_rs1 && (issue_rs1 != '0) &&
           (oc_q[issue_rs1] != '0) && (cnt_q[issue_rs1] != '0);
    raw2 = issue_use_rs2 && (issue_rs2 != '0) &&
           (oc_q[issue_rs2] != '0) && (cnt_q[issue_rs2] != '0);
    // A new write to rd must not become forwardable before an older one.
    waw  = issue_wen && (issue_rd != '0) &&
           (oc_q[issue_rd] != '0) && (cnt_q[issue_rd] > issue_lat);
    cap  = issue_wen && (issue_rd != '0) && (oc_q[issue_rd] == {OW{1'b1}});
  end

  assign stall      = issue_valid & (raw1 | raw2 | waw | cap);
  assign issue_fire = issue_valid & ~stall;

  always_comb begin
    iss_hit    = 1'b0;
    wb_hit     = 1'b0;
    busy_d     = '0;
    inflight_d = '0;
    for (int i = 0; i < NREG; i++) begin
      oc_d[i]  = '0;
      cnt_d[i] = '0;
    end
    if (!flush) begin
      for (int i = 1; i < NREG; i++) begin
        iss_hit = issue_fire && issue_wen && (issue_rd == AW'(i));
        // Writebacks to idle registers are ignored so the count never wraps.
        wb_hit  = wb_valid && (wb_addr == AW'(i)) && (oc_q[i] != '0);
        if (iss_hit) begin
          oc_d[i]  = wb_hit ? oc_q[i] : oc_q[i] + 1'b1;
          cnt_d[i] = issue_lat;
        end else begin
          oc_d[i] = oc_q[i] - OW'(wb_hit);
          if (oc_d[i] == '0)
            cnt_d[i] = '0;
          else if (cnt_q[i] != '0)
            cnt_d[i] = cnt_q[i] - 1'b1;
          else
            cnt_d[i] = '0;
        end
      end
    end
    for (int i = 1; i < NREG; i++) begin
      busy_d[i]  = (oc_d[i] != '0);
      inflight_d = inflight_d + 6'(oc_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        oc_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
      busy_mask <= '0;
      inflight  <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        oc_q[i]  <= oc_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      busy_mask <= busy_d;
      inflight  <= inflight_d;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd, wb_addr;
  logic        issue_use_rs1, issue_use_rs2, issue_wen;
  logic [2:0]  issue_lat;
  logic        wb_valid, flush;
  logic        stall, issue_fire;
  logic [31:0] busy_mask;
  logic [5:0]  inflight;

  reg_scoreboard dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
    .issue_wen(issue_wen), .issue_rd(issue_rd), .issue_lat(issue_lat),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .flush(flush),
    .stall(stall), .issue_fire(issue_fire),
    .busy_mask(busy_mask), .inflight(inflight)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference: outstanding writes and cycles-to-forwardable per register.
  int moc  [32];
  int mcnt [32];
  bit m_fire;
  bit chk_en = 0;

  logic        s_stall, s_fire;
  logic [31:0] s_busy;
  logic [5:0]  s_infl;

  task automatic check(string name, longint act, longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit src_blocked(bit use_it, int r);
    return use_it && r != 0 && moc[r] != 0 && mcnt[r] != 0;
  endfunction

  function automatic bit model_stall();
    int rd = int'(issue_rd);
    bit h;
    h = src_blocked(issue_use_rs1, int'(issue_rs1)) ||
        src_blocked(issue_use_rs2, int'(issue_rs2));
    if (issue_wen && rd != 0 && moc[rd] != 0 && mcnt[rd] > int'(issue_lat)) h = 1;
    if (issue_wen && rd != 0 && moc[rd] == 3) h = 1;
    return issue_valid && h;
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] b = '0;
    for (int i = 1; i < 32; i++) b[i] = (moc[i] != 0);
    return b;
  endfunction

  function automatic int model_infl();
    int s = 0;
    for (int i = 1; i < 32; i++) s += moc[i];
    return s % 64;
  endfunction

  task automatic model_edge();
    if (rst || flush) begin
      for (int i = 0; i < 32; i++) begin moc[i] = 0; mcnt[i] = 0; end
      return;
    end
    for (int i = 1; i < 32; i++) begin
      bit wrote   = m_fire && issue_wen && int'(issue_rd) == i;
      bit retired = wb_valid && int'(wb_addr) == i && moc[i] > 0;
      moc[i] = moc[i] + (wrote ? 1 : 0) - (retired ? 1 : 0);
      if (wrote)          mcnt[i] = int'(issue_lat);
      else if (moc[i]==0) mcnt[i] = 0;
      else if (mcnt[i]>0) mcnt[i] = mcnt[i] - 1;
    end
  endtask

  // One clock: drive, compare at negedge, advance model after posedge.
  task automatic cyc(bit v, int rs1, bit u1, int rs2, bit u2, bit wen, int rd,
                     int lat, bit wbv, int wba, bit fl, bit r);
    issue_valid = v; issue_rs1 = 5'(rs1); issue_use_rs1 = u1;
    issue_rs2 = 5'(rs2); issue_use_rs2 = u2; issue_wen = wen;
    issue_rd = 5'(rd); issue_lat = 3'(lat); wb_valid = wbv; wb_addr = 5'(wba);
    flush = fl; rst = r;
    @(negedge clk);
    s_stall = stall; s_fire = issue_fire; s_busy = busy_mask; s_infl = inflight;
    if (chk_en) begin
      m_fire = issue_valid && !model_stall();
      check("stall", s_stall, model_stall());
      check("issue_fire", s_fire, m_fire);
      check("busy_mask", s_busy, model_busy());
      check("inflight", s_infl, model_infl());
    end else m_fire = 0;
    @(posedge clk); #1;
    model_edge();
    chk_en = 1;
  endtask

  task automatic idle();                  cyc(0,0,0,0,0,0,0,0,0,0,0,0); endtask
  task automatic wr(int rd, int lat);     cyc(1,0,0,0,0,1,rd,lat,0,0,0,0); endtask
  task automatic rd1(int rs);             cyc(1,rs,1,0,0,0,0,0,0,0,0,0); endtask
  task automatic wb(int a);               cyc(0,0,0,0,0,0,0,0,1,a,0,0); endtask

  initial begin
    int n;
    cyc(0,0,0,0,0,0,0,0,0,0,0,1);
    idle();
    check("reset busy", s_busy, 32'h0);
    check("reset inflight", s_infl, 6'd0);
    check("reset stall", s_stall, 1'b0);

    // RAW on r5 with latency 2
    wr(5, 2);
    rd1(5);
    check("raw c1 stall", s_stall, 1'b1);
    check("raw busy", s_busy, 32'h20);
    check("raw inflight", s_infl, 6'd1);
    rd1(5);
    check("raw c2 stall", s_stall, 1'b1);
    rd1(5);
    check("raw c3 fire", s_fire, 1'b1);
    wb(5);

    // r0 is never tracked
    wr(0, 3);
    rd1(0);
    check("r0 stall", s_stall, 1'b0);
    check("r0 busy", s_busy, 32'h0);

    // WAW on r7
    wr(7, 4);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      wr(7, 1);
      if (s_fire) break;
      n++;
    end
    check("waw stall cycles", n, 3);
    idle();
    check("waw busy7", s_busy[7], 1'b1);
    check("waw inflight", s_infl, 6'd2);
    wb(7);
    wb(7);
    idle();
    check("waw busy7 clear", s_busy[7], 1'b0);

    // capacity on r9
    wr(9, 0); wr(9, 0); wr(9, 0);
    wr(9, 0);
    check("cap stall", s_stall, 1'b1);
    cyc(1,0,0,0,0,1,9,0,1,9,0,0);
    check("cap wb same cycle stall", s_stall, 1'b1);
    wr(9, 0);
    check("cap fire after wb", s_fire, 1'b1);
    wb(9); wb(9); wb(9);

    // issue + writeback same register
    wr(3, 1);
    cyc(1,0,0,0,0,1,3,5,1,3,0,0);
    check("iss+wb fire", s_fire, 1'b1);
    wb(12);
    check("iss+wb inflight", s_infl, 6'd1);
    rd1(3);
    check("iss+wb cnt reload", s_stall, 1'b1);
    idle();
    check("wb idle reg inflight", s_infl, 6'd1);
    wb(3);

    // flush, then reset, mid-sequence
    for (int pass = 0; pass < 2; pass++) begin
      wr(10, 7); wr(11, 7); wr(12, 7); wr(13, 7);
      cyc(1,10,1,0,0,0,0,0,0,0,pass == 0,pass == 1);
      check("pre-clear stall", s_stall, 1'b1);
      check("pre-clear inflight", s_infl, 6'd4);
      rd1(10);
      check("post-clear busy", s_busy, 32'h0);
      check("post-clear inflight", s_infl, 6'd0);
      check("post-clear stall", s_stall, 1'b0);
    end

    // randomized traffic on a small register window to provoke hazards
    for (int k = 0; k < 3000; k++) begin
      cyc($urandom_range(0,3) != 0,
          $urandom_range(0,7), $urandom_range(0,1),
          $urandom_range(0,7), $urandom_range(0,1),
          $urandom_range(0,1), $urandom_range(0,7), $urandom_range(0,7),
          $urandom_range(0,2) == 0, $urandom_range(0,7),
          $urandom_range(0,99) == 0, $urandom_range(0,299) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
